// File: rtl/shift8_seq_ctrl.sv
// shift8_seq_ctrl
//   Multi-cycle 8-bit shifter. It accepts an op, an operand and a shift amount
//   through a start/busy/done handshake. It then iterates a 0..3-position step
//   stage, applying up to 3 positions per SHIFT cycle, until the requested
//   amount is used up.
//
// Ports:
//   clk      - system clock, rising edge
//   reset_n  - asynchronous active-low reset
//   start    - request strobe, sampled while not busy (IDLE or DONE)
//   op       - 00 LSR, 01 LSL, 10 ASR, 11 ROR
//   d_in     - operand, captured with start
//   shamt    - shift amount, captured with start
//   busy     - high exactly in SHIFT cycles
//   done     - one-cycle pulse, d_out holds the result
//   d_out    - work/result register
//
// Build option:
//   SHIFT_SEQ_CLAMP_EN - pre-reduce shamt at acceptance: LSR/LSL/ASR clamp
//   values >= 8 to 8, and ROR takes shamt mod 8. Results are unchanged and
//   only the latency shrinks. The option has no effect when AMT_W <= 3.

module shift8_seq_ctrl #(
    parameter int unsigned AMT_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [7:0]       d_in,
    input  logic [AMT_W-1:0] shamt,
    output logic             busy,
    output logic             done,
    output logic [7:0]       d_out
);

    // Positions the 2-bit step stage can apply in one cycle.
    localparam int unsigned STEP_MAX = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_LSR = 2'b00,
        OP_LSL = 2'b01,
        OP_ASR = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    state_e           state_q, state_d;
    op_e              op_q;
    logic [AMT_W-1:0] rem_q;
    logic [AMT_W-1:0] eff_amt;
    logic [1:0]       step;
    logic             accept;

    // Single 4:1-mux step stage: shift d by s (0..3) positions according to o.
    function automatic logic [7:0] step_shift(input op_e o, input logic [7:0] d,
                                              input logic [1:0] s);
        logic [7:0] r;
        r = d;
        unique case (o)
            OP_LSR: r = d >> s;
            OP_LSL: r = d << s;
            OP_ASR: r = $signed(d) >>> s;
            OP_ROR: r = (d >> s) | (d << (3'd0 - 3'(s)));
        endcase
        return r;
    endfunction

    // start is only accepted outside SHIFT; while in SHIFT it is ignored.
    assign accept = start && (state_q != S_SHIFT);

`ifdef SHIFT_SEQ_CLAMP_EN
    // Reduce the amount up front. Beyond 8 positions LSR/LSL/ASR are already
    // saturated, and ROR repeats every 8 positions.
    always_comb begin
        int unsigned a;
        a = int'(shamt);
        if (op_e'(op) == OP_ROR)
            a = a % 8;
        else if (a > 8)
            a = 8;
        eff_amt = AMT_W'(a);
    end
`else
    assign eff_amt = shamt;
`endif

    // Step for the current cycle is min(remaining, STEP_MAX).
    always_comb begin
        if (rem_q >= AMT_W'(STEP_MAX))
            step = 2'(STEP_MAX);
        else
            step = rem_q[1:0];
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (accept)
                    state_d = (eff_amt == '0) ? S_DONE : S_SHIFT;
                else
                    state_d = S_IDLE;
            end
            S_SHIFT: begin
                if (rem_q == AMT_W'(step))
                    state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            S_SHIFT: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: work register, latched op and remaining count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_out <= '0;
            op_q  <= OP_LSR;
            rem_q <= '0;
        end else if (accept) begin
            d_out <= d_in;
            op_q  <= op_e'(op);
            rem_q <= eff_amt;
        end else if (state_q == S_SHIFT) begin
            d_out <= step_shift(op_q, d_out, step);
            rem_q <= rem_q - AMT_W'(step);
        end
    end

endmodule
